// File: rtl/trap_ctrl_pkg.sv
// Shared machine-mode trap constants: CSR addresses, cause codes, status/ip bit
// positions and the read-modify-write helper used by the CSR access path.
package trap_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    WFI = 1'b1
  } trap_state_t;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  localparam logic [3:0] interrupt_soft  = 4'd3;
  localparam logic [3:0] interrupt_timer = 4'd7;
  localparam logic [3:0] interrupt_ext   = 4'd11;

  localparam logic [3:0] except_inst_misalign  = 4'd0;
  localparam logic [3:0] except_inst_fault     = 4'd1;
  localparam logic [3:0] except_illegal_inst   = 4'd2;
  localparam logic [3:0] except_breakpoint     = 4'd3;
  localparam logic [3:0] except_load_misalign  = 4'd4;
  localparam logic [3:0] except_load_fault     = 4'd5;
  localparam logic [3:0] except_store_misalign = 4'd6;
  localparam logic [3:0] except_store_fault    = 4'd7;
  localparam logic [3:0] except_ecall_m        = 4'd11;

  localparam logic [11:0] csr_mstatus  = 12'h300;
  localparam logic [11:0] csr_misa     = 12'h301;
  localparam logic [11:0] csr_mie      = 12'h304;
  localparam logic [11:0] csr_mtvec    = 12'h305;
  localparam logic [11:0] csr_mscratch = 12'h340;
  localparam logic [11:0] csr_mepc     = 12'h341;
  localparam logic [11:0] csr_mcause   = 12'h342;
  localparam logic [11:0] csr_mtval    = 12'h343;
  localparam logic [11:0] csr_mip      = 12'h344;
  localparam logic [11:0] csr_mhartid  = 12'hF14;

  localparam logic [2:0] funct_csrrw  = 3'b001;
  localparam logic [2:0] funct_csrrs  = 3'b010;
  localparam logic [2:0] funct_csrrc  = 3'b011;
  localparam logic [2:0] funct_csrrwi = 3'b101;
  localparam logic [2:0] funct_csrrsi = 3'b110;
  localparam logic [2:0] funct_csrrci = 3'b111;

  localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        we;
    logic [31:0] val;
  } csr_wr_t;

  // Set/clear with a zero operand is a pure read and must not write.
  function automatic csr_wr_t csr_update(input logic [2:0]  funct,
                                         input logic [31:0] old_v,
                                         input logic [31:0] wdata);
    csr_wr_t r;
    r.we  = 1'b0;
    r.val = old_v;
    case (funct)
      funct_csrrw, funct_csrrwi: begin
        r.we  = 1'b1;
        r.val = wdata;
      end
      funct_csrrs, funct_csrrsi: begin
        r.we  = (wdata != '0);
        r.val = old_v | wdata;
      end
      funct_csrrc, funct_csrrci: begin
        r.we  = (wdata != '0);
        r.val = old_v & ~wdata;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Pending-interrupt priority encoder: external > software > timer.
module irq_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic [11:0] pend,
  output logic        valid,
  output logic [3:0]  code
);

  assign valid = |pend;

  always_comb begin
    code = 4'd0;
    if (pend[MIP_MEIP])      code = interrupt_ext;
    else if (pend[MIP_MSIP]) code = interrupt_soft;
    else if (pend[MIP_MTIP]) code = interrupt_timer;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the M-mode trap CSRs, sequences traps,
// mret and wfi, and drives a registered redirect and WFI stall to the front end.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            wfi,
  input  logic            soft_irq,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic            csr_valid,
  input  logic [2:0]      csr_funct,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall
);

  trap_state_t     state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] wake_pc_q, wake_pc_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            stall_q, stall_d;

  logic [XLEN-1:0] mstatus_w;
  logic [XLEN-1:0] mip_w;
  logic [11:0]     pend;
  logic            irq_valid;
  logic [3:0]      irq_code;
  logic            irq_take;
  csr_wr_t         csr_upd;

  logic            trap_take;
  logic            trap_irq;
  logic [XLEN-1:0] trap_epc;
  logic [3:0]      trap_code;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mtvec_base;
  logic            mret_take;
  logic            wfi_enter;
  logic            wake_take;
  logic            csr_we;

  always_comb begin
    mstatus_w                = '0;
    mstatus_w[12:11]         = MSTATUS_MPP_M;
    mstatus_w[MSTATUS_MPIE]  = mstatus_mpie_q;
    mstatus_w[MSTATUS_MIE]   = mstatus_mie_q;
  end

  // mip mirrors the interrupt lines directly; there is no storage behind it.
  always_comb begin
    mip_w           = '0;
    mip_w[MIP_MEIP] = ext_irq;
    mip_w[MIP_MTIP] = timer_irq;
    mip_w[MIP_MSIP] = soft_irq;
  end

  assign pend     = mip_w[11:0] & mie_q[11:0];
  assign irq_take = mstatus_mie_q & irq_valid;

  irq_prio_enc u_prio (
    .pend  (pend),
    .valid (irq_valid),
    .code  (irq_code)
  );

  always_comb begin
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      csr_mstatus:           csr_rdata = mstatus_w;
      csr_mie:               csr_rdata = mie_q;
      csr_mtvec:             csr_rdata = mtvec_q;
      csr_mscratch:          csr_rdata = mscratch_q;
      csr_mepc:              csr_rdata = mepc_q;
      csr_mcause:            csr_rdata = mcause_q;
      csr_mtval:             csr_rdata = mtval_q;
      csr_mip:               csr_rdata = mip_w;
      csr_misa, csr_mhartid: csr_rdata = '0;
      default:               csr_illegal = 1'b1;
    endcase
  end

  assign csr_upd = csr_update(csr_funct, csr_rdata, csr_wdata);

  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (trap_irq && (mtvec_q[1:0] == 2'b01))
                     ? mtvec_base + {{(XLEN-6){1'b0}}, trap_code, 2'b00}
                     : mtvec_base;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= RUN;
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= MTVEC_RESET;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      wake_pc_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      mstatus_mie_q    <= mstatus_mie_d;
      mstatus_mpie_q   <= mstatus_mpie_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      wake_pc_q        <= wake_pc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stall_q          <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: if (commit_valid && !irq_take && !exc_valid && !mret && wfi) state_d = WFI;
      WFI: if (irq_valid) state_d = RUN;
    endcase
  end

  // One action per cycle: interrupt beats exception beats mret/wfi beats CSR write.
  always_comb begin
    trap_take = 1'b0;
    trap_irq  = 1'b0;
    trap_epc  = commit_pc;
    trap_code = irq_code;
    mret_take = 1'b0;
    wfi_enter = 1'b0;
    wake_take = 1'b0;
    csr_we    = 1'b0;
    case (state_q)
      RUN: begin
        if (commit_valid) begin
          if (irq_take) begin
            trap_take = 1'b1;
            trap_irq  = 1'b1;
          end else if (exc_valid) begin
            trap_take = 1'b1;
            trap_code = exc_cause;
          end else if (mret) begin
            mret_take = 1'b1;
          end else if (wfi) begin
            wfi_enter = 1'b1;
          end else if (csr_valid && !csr_illegal) begin
            csr_we = csr_upd.we;
          end
        end
      end
      WFI: begin
        if (irq_valid) begin
          if (mstatus_mie_q) begin
            trap_take = 1'b1;
            trap_irq  = 1'b1;
            trap_epc  = wake_pc_q;
          end else begin
            wake_take = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    mstatus_mie_d    = mstatus_mie_q;
    mstatus_mpie_d   = mstatus_mpie_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    wake_pc_d        = wake_pc_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    stall_d          = stall_q;
    if (trap_take) begin
      mepc_d           = trap_epc;
      mcause_d         = {trap_irq, {(XLEN-5){1'b0}}, trap_code};
      mtval_d          = trap_irq ? '0 : exc_tval;
      mstatus_mpie_d   = mstatus_mie_q;
      mstatus_mie_d    = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_target;
      stall_d          = 1'b0;
    end else if (mret_take) begin
      mstatus_mie_d    = mstatus_mpie_q;
      mstatus_mpie_d   = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (wfi_enter) begin
      wake_pc_d = commit_pc + 32'd4;
      stall_d   = 1'b1;
    end else if (wake_take) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = wake_pc_q;
      stall_d          = 1'b0;
    end else if (csr_we) begin
      case (csr_addr)
        csr_mstatus: begin
          mstatus_mie_d  = csr_upd.val[MSTATUS_MIE];
          mstatus_mpie_d = csr_upd.val[MSTATUS_MPIE];
        end
        csr_mie:      mie_d      = csr_upd.val & MIE_WMASK;
        csr_mtvec:    mtvec_d    = csr_upd.val & MTVEC_WMASK;
        csr_mscratch: mscratch_d = csr_upd.val;
        csr_mepc:     mepc_d     = csr_upd.val & MEPC_WMASK;
        csr_mcause:   mcause_d   = csr_upd.val;
        csr_mtval:    mtval_d    = csr_upd.val;
        default: ;
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall          = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized commit traffic
// compared cycle by cycle against a behavioural trap model.
module tb_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mret;
  logic        wfi;
  logic        soft_irq;
  logic        timer_irq;
  logic        ext_irq;
  logic        csr_valid;
  logic [2:0]  csr_funct;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  always #5 clock = ~clock;

  trap_ctrl #(.MTVEC_RESET(32'h0000_0000), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret),
    .wfi(wfi), .soft_irq(soft_irq), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_valid(csr_valid), .csr_funct(csr_funct), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model state: current values and next-cycle values.
  bit          md_sleep, md_mie_bit, md_mpie, md_rv, md_stall;
  logic [31:0] md_mie, md_mtvec, md_mscratch, md_mepc, md_mcause, md_mtval, md_wake, md_rpc;
  bit          nx_sleep, nx_mie_bit, nx_mpie, nx_rv, nx_stall;
  logic [31:0] nx_mie, nx_mtvec, nx_mscratch, nx_mepc, nx_mcause, nx_mtval, nx_wake, nx_rpc;

  function automatic logic [31:0] md_mip();
    return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0) | (soft_irq ? 32'h8 : 32'h0);
  endfunction

  function automatic bit md_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'h343, 12'h344, 12'hF14};
  endfunction

  function automatic logic [31:0] md_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (md_mpie ? 32'h80 : 32'h0) | (md_mie_bit ? 32'h8 : 32'h0);
      12'h304: return md_mie;
      12'h305: return md_mtvec;
      12'h340: return md_mscratch;
      12'h341: return md_mepc;
      12'h342: return md_mcause;
      12'h343: return md_mtval;
      12'h344: return md_mip();
      default: return 32'h0;
    endcase
  endfunction

  function automatic int md_irq_code(input logic [31:0] p);
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    return -1;
  endfunction

  task automatic md_trap(input bit is_irq, input int code, input logic [31:0] epc,
                         input logic [31:0] tval);
    logic [31:0] base;
    base      = md_mtvec & ~32'h3;
    nx_mepc   = epc;
    nx_mcause = (is_irq ? 32'h8000_0000 : 32'h0) + 32'(code);
    nx_mtval  = is_irq ? 32'h0 : tval;
    nx_mpie   = md_mie_bit;
    nx_mie_bit = 1'b0;
    nx_rv     = 1'b1;
    nx_rpc    = (is_irq && md_mtvec[1:0] == 2'd1) ? base + 32'(4 * code) : base;
    nx_stall  = 1'b0;
  endtask

  task automatic md_csr_write();
    logic [31:0] old_v, v;
    bit          we;
    old_v = md_read(csr_addr);
    we    = 1'b0;
    v     = old_v;
    case (csr_funct[1:0])
      2'd1: begin we = 1'b1; v = csr_wdata; end
      2'd2: begin we = (csr_wdata != 0); v = old_v | csr_wdata; end
      2'd3: begin we = (csr_wdata != 0); v = old_v & ~csr_wdata; end
      default: ;
    endcase
    if (!we) return;
    case (csr_addr)
      12'h300: begin nx_mie_bit = v[3]; nx_mpie = v[7]; end
      12'h304: nx_mie      = v & 32'h888;
      12'h305: nx_mtvec    = v & ~32'h2;
      12'h340: nx_mscratch = v;
      12'h341: nx_mepc     = v & ~32'h3;
      12'h342: nx_mcause   = v;
      12'h343: nx_mtval    = v;
      default: ;
    endcase
  endtask

  task automatic md_step();
    int code;
    code = md_irq_code(md_mip() & md_mie);
    nx_sleep = md_sleep; nx_mie_bit = md_mie_bit; nx_mpie = md_mpie; nx_mie = md_mie;
    nx_mtvec = md_mtvec; nx_mscratch = md_mscratch; nx_mepc = md_mepc;
    nx_mcause = md_mcause; nx_mtval = md_mtval; nx_wake = md_wake;
    nx_rv = 1'b0; nx_rpc = md_rpc; nx_stall = md_stall;
    if (reset) begin
      nx_sleep = 0; nx_mie_bit = 0; nx_mpie = 0; nx_mie = 0; nx_mtvec = 0; nx_mscratch = 0;
      nx_mepc = 0; nx_mcause = 0; nx_mtval = 0; nx_rpc = 0; nx_stall = 0;
    end else if (md_sleep) begin
      if (code >= 0) begin
        nx_sleep = 0;
        nx_stall = 0;
        if (md_mie_bit) md_trap(1'b1, code, md_wake, 32'h0);
        else begin nx_rv = 1'b1; nx_rpc = md_wake; end
      end
    end else if (commit_valid) begin
      if (md_mie_bit && code >= 0) md_trap(1'b1, code, commit_pc, 32'h0);
      else if (exc_valid) md_trap(1'b0, int'(exc_cause), commit_pc, exc_tval);
      else if (mret) begin
        nx_mie_bit = md_mpie; nx_mpie = 1'b1; nx_rv = 1'b1; nx_rpc = md_mepc;
      end else if (wfi) begin
        nx_wake = commit_pc + 32'd4; nx_sleep = 1'b1; nx_stall = 1'b1;
      end else if (csr_valid && md_legal(csr_addr)) md_csr_write();
    end
  endtask

  task automatic md_commit();
    md_sleep = nx_sleep; md_mie_bit = nx_mie_bit; md_mpie = nx_mpie; md_mie = nx_mie;
    md_mtvec = nx_mtvec; md_mscratch = nx_mscratch; md_mepc = nx_mepc;
    md_mcause = nx_mcause; md_mtval = nx_mtval; md_wake = nx_wake;
    md_rv = nx_rv; md_rpc = nx_rpc; md_stall = nx_stall;
  endtask

  task automatic idle();
    commit_valid = 0; commit_pc = 0; exc_valid = 0; exc_cause = 0; exc_tval = 0;
    mret = 0; wfi = 0; soft_irq = 0; timer_irq = 0; ext_irq = 0;
    csr_valid = 0; csr_funct = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic step();
    #1;
    check_val("csr_rdata", csr_rdata, md_read(csr_addr));
    check_val("csr_illegal", 32'(csr_illegal), 32'(!md_legal(csr_addr)));
    md_step();
    @(posedge clock);
    #1;
    md_commit();
    check_val("redirect_valid", 32'(redirect_valid), 32'(md_rv));
    check_val("redirect_pc", redirect_pc, md_rpc);
    check_val("stall", 32'(stall), 32'(md_stall));
  endtask

  task automatic csr_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d);
    idle();
    commit_valid = 1; csr_valid = 1; csr_funct = f; csr_addr = a; csr_wdata = d;
    commit_pc = $urandom & ~32'h3;
    step();
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle();
    csr_addr = a;
    #1;
    check_val(tag, csr_rdata, exp);
    step();
  endtask

  logic [11:0] addr_pool [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'h301, 12'hF14, 12'h7C0, 12'h000};

  initial begin
    idle();
    reset = 1;
    md_sleep = 0; md_mie_bit = 0; md_mpie = 0; md_rv = 0; md_stall = 0;
    md_mie = 0; md_mtvec = 0; md_mscratch = 0; md_mepc = 0; md_mcause = 0;
    md_mtval = 0; md_wake = 0; md_rpc = 0;
    step();
    step();
    reset = 0;
    peek("rst_mstatus", 12'h300, 32'h1800);
    peek("rst_mtvec", 12'h305, 32'h0);

    // synchronous exception, direct mode
    csr_op(3'b001, 12'h305, 32'h200);
    idle();
    commit_valid = 1; commit_pc = 32'h100; exc_valid = 1; exc_cause = 4'd2; exc_tval = 32'hDEADBEEF;
    step();
    check_val("exc_rv", 32'(redirect_valid), 32'h1);
    check_val("exc_rpc", redirect_pc, 32'h200);
    peek("exc_mepc", 12'h341, 32'h100);
    peek("exc_mcause", 12'h342, 32'h2);
    peek("exc_mtval", 12'h343, 32'hDEADBEEF);
    peek("exc_mstatus", 12'h300, 32'h1800);

    // vectored timer interrupt
    csr_op(3'b001, 12'h305, 32'h201);
    csr_op(3'b001, 12'h304, 32'h80);
    csr_op(3'b001, 12'h300, 32'h8);
    idle();
    timer_irq = 1; commit_valid = 1; commit_pc = 32'h40;
    step();
    check_val("vec_rpc", redirect_pc, 32'h21C);
    peek("vec_mcause", 12'h342, 32'h8000_0007);
    peek("vec_mepc", 12'h341, 32'h40);
    peek("vec_mstatus", 12'h300, 32'h1880);

    // all three lines plus an exception: external wins, exception dropped
    csr_op(3'b001, 12'h304, 32'h888);
    csr_op(3'b001, 12'h300, 32'h8);
    idle();
    ext_irq = 1; soft_irq = 1; timer_irq = 1; exc_valid = 1; exc_cause = 4'd5;
    exc_tval = 32'h1234_5678; commit_valid = 1; commit_pc = 32'h60;
    step();
    check_val("prio_rpc", redirect_pc, 32'h22C);
    peek("prio_mcause", 12'h342, 32'h8000_000B);
    peek("prio_mtval", 12'h343, 32'h0);

    // mret
    idle();
    mret = 1; commit_valid = 1; commit_pc = 32'h300;
    step();
    check_val("mret_rv", 32'(redirect_valid), 32'h1);
    check_val("mret_rpc", redirect_pc, 32'h60);
    peek("mret_mstatus", 12'h300, 32'h1888);

    // WFI with MIE=0: wake without trapping
    csr_op(3'b001, 12'h300, 32'h0);
    csr_op(3'b001, 12'h304, 32'h8);
    idle();
    wfi = 1; commit_valid = 1; commit_pc = 32'h80;
    step();
    check_val("wfi_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 5; i++) begin
      idle();
      commit_valid = 1; exc_valid = 1; commit_pc = 32'h500;
      step();
      check_val("wfi_hold", 32'(stall), 32'h1);
    end
    idle();
    soft_irq = 1;
    step();
    check_val("wake_rv", 32'(redirect_valid), 32'h1);
    check_val("wake_rpc", redirect_pc, 32'h84);
    check_val("wake_stall", 32'(stall), 32'h0);
    peek("wake_mcause", 12'h342, 32'h8000_000B);

    // WFI with MIE=1: wake into the vector
    csr_op(3'b001, 12'h300, 32'h8);
    idle();
    wfi = 1; commit_valid = 1; commit_pc = 32'h80;
    step();
    for (int i = 0; i < 5; i++) begin
      idle();
      step();
    end
    idle();
    soft_irq = 1;
    step();
    check_val("wfi_irq_rpc", redirect_pc, 32'h20C);
    check_val("wfi_irq_stall", 32'(stall), 32'h0);
    peek("wfi_irq_mepc", 12'h341, 32'h84);
    peek("wfi_irq_mcause", 12'h342, 32'h8000_0003);

    // CSR set on mie after reset, then an unowned address
    idle();
    reset = 1;
    step();
    reset = 0;
    idle();
    commit_valid = 1; csr_valid = 1; csr_funct = 3'b010; csr_addr = 12'h304; csr_wdata = 32'hFFFF_FFFF;
    #1;
    check_val("csrrs_old", csr_rdata, 32'h0);
    step();
    peek("csrrs_mie", 12'h304, 32'h888);
    idle();
    commit_valid = 1; csr_valid = 1; csr_funct = 3'b001; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    #1;
    check_val("illegal_flag", 32'(csr_illegal), 32'h1);
    step();
    peek("illegal_mscratch", 12'h340, 32'h0);
    peek("illegal_mstatus", 12'h300, 32'h1800);

    // reset while sleeping
    idle();
    wfi = 1; commit_valid = 1; commit_pc = 32'h100;
    step();
    check_val("rst_wfi_stall_pre", 32'(stall), 32'h1);
    idle();
    reset = 1;
    step();
    check_val("rst_wfi_stall", 32'(stall), 32'h0);
    check_val("rst_wfi_rv", 32'(redirect_valid), 32'h0);
    reset = 0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic s, t, e;
      s = soft_irq; t = timer_irq; e = ext_irq;
      idle();
      soft_irq  = ($urandom_range(0, 19) == 0) ? ~s : s;
      timer_irq = ($urandom_range(0, 19) == 0) ? ~t : t;
      ext_irq   = ($urandom_range(0, 29) == 0) ? ~e : e;
      reset        = ($urandom_range(0, 99) == 0);
      commit_valid = ($urandom_range(0, 9) < 7);
      commit_pc    = $urandom & ~32'h3;
      exc_valid    = ($urandom_range(0, 9) == 0);
      exc_cause    = 4'($urandom);
      exc_tval     = $urandom;
      mret         = ($urandom_range(0, 19) == 0);
      wfi          = ($urandom_range(0, 24) == 0);
      csr_valid    = ($urandom_range(0, 9) < 5);
      csr_funct    = 3'($urandom);
      csr_addr     = addr_pool[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       csr_wdata = 32'h0;
        1:       csr_wdata = 32'hFFFF_FFFF;
        default: csr_wdata = $urandom;
      endcase
      step();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
